mac_feeder: RTL and testbench
=============================

Name: mac_feeder

Overview:
Sequencer that drives the mac_core operand interface for one fully connected layer. For each of NEURONS output neurons it performs the following steps:
- Clears the MAC.
- Streams WIDTH pixel/weight pairs from the image and weight RAMs.
- Waits for the RAM and MAC pipeline to drain.
- Captures the accumulator and presents it on a valid/ready result port.

It sits between the image/weight memories and mac_core, and upstream of the classifier output logic.

Parameters:
- BITS_INT, 4, pixel integer bits
- BITS_FRC, 12, pixel fraction bits
- WGHT_INT, 6, weight integer bits
- WGHT_FRC, 10, weight fraction bits
- WIDTH, 784, pixels per neuron (>=2)
- NEURONS, 10, neurons per layer (>=1)
- RD_LAT, 1, RAM read latency in cycles (>=1)
- Derived: PW=BITS_INT+BITS_FRC, WW=WGHT_INT+WGHT_FRC, AW=PW+WW, PA=$clog2(WIDTH), WA=$clog2(WIDTH*NEURONS), NI=$clog2(NEURONS) (min 1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- start_i  in  1  start one layer pass; sampled only in IDLE
- busy_o  out  1  high in any state other than IDLE
- pix_addr_o  out  PA  image RAM address
- pix_data_i  in  PW  image RAM data, RD_LAT cycles after address
- wght_addr_o  out  WA  weight RAM address, neuron*WIDTH+element
- wght_data_i  in  WW  weight RAM data, RD_LAT cycles after address
- mac_clr_n_o  out  1  to mac_core reset (active-low, sampled synchronously by MAC)
- mac_pic_o  out  PW  to mac_core picture_i
- mac_wght_o  out  WW  to mac_core weight_i
- mac_acc_i  in  AW  from mac_core acc
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result accepted
- res_data_o  out  AW  signed accumulator result, Q(BITS_INT+WGHT_INT).(BITS_FRC+WGHT_FRC)
- res_idx_o  out  NI  neuron index of res_data_o
- done_o  out  1  one-cycle pulse after the last result handshake
- pred_o  out  NI  argmax index (see Optional Feature)

Behaviour:
Reset:
- On reset low, asynchronously enter IDLE.
- All counters, res_data_o, res_idx_o, pred_o and addresses go to 0.
- res_valid_o, done_o and busy_o go to 0; mac_clr_n_o goes to 0.
- Reset mid-operation abandons the pass; no partial result is emitted.

Operand gating:
- mac_core accumulates every cycle while its clear is high.
- mac_pic_o and mac_wght_o therefore equal the RAM data only when a RD_LAT-deep valid shift register (fed by FEED cycles) reports valid data; otherwise they are 0.

mac_clr_n_o:
- High only in FEED and DRAIN; low in IDLE and OUT.
- This guarantees acc=0 at the first FEED cycle.

State machine:
- IDLE: start_i=1 -> FEED, neuron=0, elem=0. Otherwise remain in IDLE.
- FEED:
  - pix_addr_o=elem; wght_addr_o=neuron*WIDTH+elem (running base register, no multiplier).
  - elem increments each cycle.
  - When elem==WIDTH-1 -> DRAIN. Exactly WIDTH cycles are spent in FEED.
- DRAIN:
  - Lasts RD_LAT+1 cycles.
  - On exit, latch mac_acc_i into res_data_o and neuron into res_idx_o -> OUT.
- OUT:
  - res_valid_o=1; res_data_o and res_idx_o are held stable until res_valid_o && res_ready_i.
  - On handshake: if neuron==NEURONS-1 -> IDLE with done_o=1 for one cycle.
  - Otherwise neuron+1, elem=0, base+=WIDTH -> FEED.

Latency and rules:
- res_valid_o rises WIDTH+RD_LAT+1 rising edges after the edge that samples start_i.
- start_i during busy is ignored.
- res_ready_i outside OUT is ignored.
- Addresses hold their last value outside FEED.

Optional Feature:
- Macro: MAC_FEEDER_ARGMAX_EN.
- Defined:
  - Track a running signed maximum of captured results.
  - The first neuron initialises the maximum.
  - A later neuron replaces it only if strictly greater, so ties keep the lower index.
  - pred_o updates in the same cycle done_o pulses and holds until the next start.
  - Cleared to 0 on reset and on start.
- Undefined: pred_o is tied to 0 and no comparator is built.

Test Plan:
1. WIDTH=4, NEURONS=2, RD_LAT=1, all pixels 0x1000 (1.0):
   - Neuron0 weights 0x0400 -> res_data_o=0x01000000, res_idx_o=0.
   - Neuron1 weights 0xFE00 -> res_data_o=0xFF800000, res_idx_o=1.
   - done_o pulses once; with ARGMAX pred_o=0.
2. Same config, start_i pulsed: res_valid_o rises exactly 6 edges after start is sampled; wght_addr_o sequence is 0,1,2,3 then 4,5,6,7.
3. Backpressure:
   - Hold res_ready_i=0 for 5 cycles in OUT -> res_valid_o stays 1, res_data_o stable, no address changes, mac_clr_n_o=0.
   - Release -> next neuron starts.
4. Assert reset low during FEED at elem=2:
   - All outputs go to 0 immediately, busy_o=0.
   - A new start produces correct neuron0 result 0x01000000.
5. Pulse start_i while busy -> no restart: addresses continue unchanged, and exactly NEURONS results are emitted.
6. ARGMAX tie, both neurons weights 0x0400 -> pred_o=0. Neuron1 weights 0x0800 -> pred_o=1.

Source files
------------

// File: rtl/mac_feeder.sv
// mac_feeder: sequences one fully connected layer through mac_core.
// Each neuron goes through four steps: clear the MAC, stream WIDTH pixel/weight
// pairs, drain the RAM and MAC pipeline, then present the accumulator on a
// valid/ready result port.
// Optional build macro MAC_FEEDER_ARGMAX_EN adds a running signed argmax on pred_o.
// Without that macro, pred_o is tied to 0.
module mac_feeder #(
  parameter int BITS_INT = 4,
  parameter int BITS_FRC = 12,
  parameter int WGHT_INT = 6,
  parameter int WGHT_FRC = 10,
  parameter int WIDTH    = 784,
  parameter int NEURONS  = 10,
  parameter int RD_LAT   = 1,
  localparam int PW = BITS_INT + BITS_FRC,
  localparam int WW = WGHT_INT + WGHT_FRC,
  localparam int AW = PW + WW,
  localparam int PA = $clog2(WIDTH),
  localparam int WA = $clog2(WIDTH * NEURONS),
  localparam int NI = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  output logic          busy_o,
  output logic [PA-1:0] pix_addr_o,
  input  logic [PW-1:0] pix_data_i,
  output logic [WA-1:0] wght_addr_o,
  input  logic [WW-1:0] wght_data_i,
  output logic          mac_clr_n_o,
  output logic [PW-1:0] mac_pic_o,
  output logic [WW-1:0] mac_wght_o,
  input  logic [AW-1:0] mac_acc_i,
  output logic          res_valid_o,
  input  logic          res_ready_i,
  output logic [AW-1:0] res_data_o,
  output logic [NI-1:0] res_idx_o,
  output logic          done_o,
  output logic [NI-1:0] pred_o
);

  localparam int DW = $clog2(RD_LAT + 1) + 1;
  localparam logic [PA-1:0] ELEM_LAST   = PA'(WIDTH - 1);
  localparam logic [NI-1:0] NEURON_LAST = NI'(NEURONS - 1);
  localparam logic [WA-1:0] W_STEP      = WA'(WIDTH);
  localparam logic [DW-1:0] DRAIN_LAST  = DW'(RD_LAT);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_OUT} state_t;

  state_t            state_q,     state_d;
  logic [PA-1:0]     elem_q,      elem_d;
  logic [NI-1:0]     neuron_q,    neuron_d;
  logic [WA-1:0]     base_q,      base_d;
  logic [WA-1:0]     wght_addr_q, wght_addr_d;
  logic [RD_LAT-1:0] vld_q,       vld_d;
  logic [DW-1:0]     drain_q,     drain_d;
  logic              res_valid_q, res_valid_d;
  logic [AW-1:0]     res_data_q,  res_data_d;
  logic [NI-1:0]     res_idx_q,   res_idx_d;
  logic              done_q,      done_d;
  logic              clr_n_q,     clr_n_d;
  logic              busy_q,      busy_d;
`ifdef MAC_FEEDER_ARGMAX_EN
  logic [AW-1:0]     max_q,       max_d;
  logic [NI-1:0]     arg_q,       arg_d;
  logic [NI-1:0]     pred_q,      pred_d;
`endif

  // Next-state logic for the sequencer, counters, result capture and argmax.
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    neuron_d    = neuron_q;
    base_d      = base_q;
    wght_addr_d = wght_addr_q;
    drain_d     = drain_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_idx_d   = res_idx_q;
    done_d      = 1'b0;
    clr_n_d     = clr_n_q;
    busy_d      = busy_q;
`ifdef MAC_FEEDER_ARGMAX_EN
    max_d       = max_q;
    arg_d       = arg_q;
    pred_d      = pred_q;
`endif
    // Operand-valid pipeline mirrors the RAM read latency.
    vld_d[0] = (state_q == S_FEED);
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_FEED;
          elem_d      = '0;
          neuron_d    = '0;
          base_d      = '0;
          wght_addr_d = '0;
          clr_n_d     = 1'b1;
          busy_d      = 1'b1;
`ifdef MAC_FEEDER_ARGMAX_EN
          pred_d      = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FEED: begin
        if (elem_q == ELEM_LAST) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          elem_d      = elem_q + PA'(1);
          wght_addr_d = wght_addr_q + WA'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d     = S_OUT;
          res_data_d  = mac_acc_i;
          res_idx_d   = neuron_q;
          res_valid_d = 1'b1;
          clr_n_d     = 1'b0;
`ifdef MAC_FEEDER_ARGMAX_EN
          // Strictly-greater replacement keeps the lower index on ties.
          if ((neuron_q == '0) || ($signed(mac_acc_i) > $signed(max_q))) begin
            max_d = mac_acc_i;
            arg_d = neuron_q;
          end else begin
            max_d = max_q;
          end
`endif
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      S_OUT: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          if (neuron_q == NEURON_LAST) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`ifdef MAC_FEEDER_ARGMAX_EN
            pred_d  = arg_q;
`endif
          end else begin
            state_d     = S_FEED;
            neuron_d    = neuron_q + NI'(1);
            elem_d      = '0;
            base_d      = base_q + W_STEP;
            wght_addr_d = base_q + W_STEP;
            clr_n_d     = 1'b1;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        clr_n_d     = 1'b0;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset abandons any pass in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      elem_q      <= '0;
      neuron_q    <= '0;
      base_q      <= '0;
      wght_addr_q <= '0;
      vld_q       <= '0;
      drain_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      done_q      <= 1'b0;
      clr_n_q     <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MAC_FEEDER_ARGMAX_EN
      max_q       <= '0;
      arg_q       <= '0;
      pred_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      neuron_q    <= neuron_d;
      base_q      <= base_d;
      wght_addr_q <= wght_addr_d;
      vld_q       <= vld_d;
      drain_q     <= drain_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
      done_q      <= done_d;
      clr_n_q     <= clr_n_d;
      busy_q      <= busy_d;
`ifdef MAC_FEEDER_ARGMAX_EN
      max_q       <= max_d;
      arg_q       <= arg_d;
      pred_q      <= pred_d;
`endif
    end
  end

  // Element counter doubles as the image address and holds outside FEED.
  assign pix_addr_o  = elem_q;
  assign wght_addr_o = wght_addr_q;
  assign busy_o      = busy_q;
  assign mac_clr_n_o = clr_n_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_idx_o   = res_idx_q;
  assign done_o      = done_q;
  // The MAC accumulates every enabled cycle, so only valid RAM data may pass.
  assign mac_pic_o   = vld_q[RD_LAT-1] ? pix_data_i  : '0;
  assign mac_wght_o  = vld_q[RD_LAT-1] ? wght_data_i : '0;
`ifdef MAC_FEEDER_ARGMAX_EN
  assign pred_o      = pred_q;
`else
  assign pred_o      = '0;
`endif

endmodule

// File: tb/tb_mac_feeder.sv
// Self-checking bench for mac_feeder (WIDTH=4, NEURONS=2, RD_LAT=1).
// Results are scored through an expected-value queue popped by a monitor.
module tb_mac_feeder;

  localparam int WIDTH   = 4;
  localparam int NEURONS = 2;
  localparam int RD_LAT  = 1;
`ifdef MAC_FEEDER_ARGMAX_EN
  localparam bit AM = 1'b1;
`else
  localparam bit AM = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic [1:0]  pix_addr;
  logic [15:0] pix_data;
  logic [2:0]  wght_addr;
  logic [15:0] wght_data;
  logic        mac_clr_n;
  logic [15:0] mac_pic;
  logic [15:0] mac_wght;
  logic [31:0] mac_acc;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [0:0]  res_idx;
  logic        done;
  logic [0:0]  pred;

  mac_feeder #(
    .BITS_INT(4), .BITS_FRC(12), .WGHT_INT(6), .WGHT_FRC(10),
    .WIDTH(WIDTH), .NEURONS(NEURONS), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start), .busy_o(busy),
    .pix_addr_o(pix_addr), .pix_data_i(pix_data),
    .wght_addr_o(wght_addr), .wght_data_i(wght_data),
    .mac_clr_n_o(mac_clr_n), .mac_pic_o(mac_pic), .mac_wght_o(mac_wght),
    .mac_acc_i(mac_acc), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_idx_o(res_idx), .done_o(done), .pred_o(pred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories with one cycle read latency, plus a mac_core model.
  logic [15:0] pmem [0:3];
  logic [15:0] wmem [0:7];
  logic signed [31:0] prod;
  initial begin
    pix_data  = 16'h0000;
    wght_data = 16'h0000;
    mac_acc   = 32'h0000_0000;
  end
  assign prod = $signed(mac_pic) * $signed(mac_wght);
  always @(posedge clk) begin
    pix_data  <= pmem[pix_addr];
    wght_data <= wmem[wght_addr];
    if (!mac_clr_n) mac_acc <= 32'h0000_0000;
    else            mac_acc <= mac_acc + prod;
  end

  typedef struct packed {
    logic [31:0] d;
    logic [0:0]  i;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   vec_cnt;
  int   err_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [0:0] i);
    exp_t e;
    e.d = d;
    e.i = i;
    sb.push_back(e);
  endtask

  task automatic set_w(input logic [15:0] w0, input logic [15:0] w1);
    for (int e = 0; e < WIDTH; e++) begin
      wmem[e]         = w0;
      wmem[WIDTH + e] = w1;
    end
  endtask

  // Monitor: score every result handshake against the queue.
  always @(negedge clk) begin
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      vec_cnt++;
      if (sb.size() == 0) begin
        err_cnt++;
        $display("FAIL result_unexpected: got data %0h idx %0h expected none", res_data, res_idx);
      end else begin
        mon_e = sb.pop_front();
        if (res_data !== mon_e.d || res_idx !== mon_e.i) begin
          err_cnt++;
          $display("FAIL result: got data %0h idx %0h expected data %0h idx %0h",
                   res_data, res_idx, mon_e.d, mon_e.i);
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Checks addresses through one FEED phase and the latency to res_valid.
  task automatic feed_check(input int base, input bit poke);
    int k;
    for (k = 1; k <= 12; k++) begin
      if (k <= WIDTH) begin
        chk("wght_addr", 64'(wght_addr), 64'(base + k - 1));
        chk("pix_addr",  64'(pix_addr),  64'(k - 1));
      end
      if (k == 1) chk("clr_n_feed", 64'(mac_clr_n), 64'(1));
      if (poke && k == 2) start = 1'b1;
      if (poke && k == 3) start = 1'b0;
      @(posedge clk); #1;
      if (res_valid) break;
    end
    chk("valid_latency", 64'(k), 64'(WIDTH + RD_LAT + 1));
  endtask

  task automatic run_pass(input bit poke, input int bp, input logic [0:0] exp_pred);
    logic [31:0] hd;
    logic [2:0]  hw;
    logic [1:0]  hp;
    if (bp > 0) res_ready = 1'b0;
    pulse_start();
    chk("pred_cleared", 64'(pred), 64'(0));
    feed_check(0, poke);
    if (bp > 0) begin
      hd = res_data;
      hw = wght_addr;
      hp = pix_addr;
      repeat (bp) begin
        @(posedge clk); #1;
        chk("bp_valid", 64'(res_valid), 64'(1));
        chk("bp_data",  64'(res_data),  64'(hd));
        chk("bp_waddr", 64'(wght_addr), 64'(hw));
        chk("bp_paddr", 64'(pix_addr),  64'(hp));
        chk("bp_clr_n", 64'(mac_clr_n), 64'(0));
      end
      res_ready = 1'b1;
    end
    @(posedge clk); #1;
    feed_check(WIDTH, poke);
    @(posedge clk); #1;
    chk("done_pulse", 64'(done), 64'(1));
    chk("pred",       64'(pred), 64'(exp_pred));
    chk("busy_end",   64'(busy), 64'(0));
    @(posedge clk); #1;
    chk("done_clear", 64'(done), 64'(0));
    chk("pred_hold",  64'(pred), 64'(exp_pred));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    reset     = 1'b0;
    start     = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < WIDTH; i++) pmem[i] = 16'h1000;
    set_w(16'h0400, 16'hFE00);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  64'(busy),      64'(0));
    chk("rst_valid", 64'(res_valid), 64'(0));
    chk("rst_done",  64'(done),      64'(0));
    chk("rst_clr_n", 64'(mac_clr_n), 64'(0));
    chk("rst_paddr", 64'(pix_addr),  64'(0));
    chk("rst_waddr", 64'(wght_addr), 64'(0));
    chk("rst_data",  64'(res_data),  64'(0));
    chk("rst_idx",   64'(res_idx),   64'(0));
    chk("rst_pred",  64'(pred),      64'(0));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 64'(busy), 64'(0));

    // Basic pass: +1.0 and -0.5 weights, latency and address sequence.
    push_exp(32'h0100_0000, 1'b0);
    push_exp(32'hFF80_0000, 1'b1);
    run_pass(1'b0, 0, 1'b0);

    // Backpressure for 5 cycles on neuron 0.
    push_exp(32'h0100_0000, 1'b0);
    push_exp(32'hFF80_0000, 1'b1);
    run_pass(1'b0, 5, 1'b0);

    // Reset during FEED at elem 2, then a clean pass.
    pulse_start();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_elem", 64'(pix_addr), 64'(2));
    reset = 1'b0;
    #1;
    chk("abort_busy",  64'(busy),      64'(0));
    chk("abort_valid", 64'(res_valid), 64'(0));
    chk("abort_clr_n", 64'(mac_clr_n), 64'(0));
    chk("abort_paddr", 64'(pix_addr),  64'(0));
    chk("abort_waddr", 64'(wght_addr), 64'(0));
    chk("abort_pic",   64'(mac_pic),   64'(0));
    chk("abort_wght",  64'(mac_wght),  64'(0));
    chk("abort_data",  64'(res_data),  64'(0));
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_idle", 64'(busy), 64'(0));
    push_exp(32'h0100_0000, 1'b0);
    push_exp(32'hFF80_0000, 1'b1);
    run_pass(1'b0, 0, 1'b0);

    // start_i while busy is ignored; exactly NEURONS results.
    push_exp(32'h0100_0000, 1'b0);
    push_exp(32'hFF80_0000, 1'b1);
    run_pass(1'b1, 0, 1'b0);
    chk("no_restart", 64'(busy), 64'(0));
    chk("sb_empty_busy_start", 64'(sb.size()), 64'(0));

    // Argmax: tie keeps the lower index, larger later neuron wins.
    set_w(16'h0400, 16'h0400);
    push_exp(32'h0100_0000, 1'b0);
    push_exp(32'h0100_0000, 1'b1);
    run_pass(1'b0, 0, 1'b0);
    set_w(16'h0400, 16'h0800);
    push_exp(32'h0100_0000, 1'b0);
    push_exp(32'h0200_0000, 1'b1);
    run_pass(1'b0, 0, AM ? 1'b1 : 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty_final", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
